spi_cs_scheduler: RTL and testbench

//  Shares one SPI_master between NUM_REQ requesters. Arbitrates round-robin,

---
 rtl/spi_cs_scheduler_if.sv | 28 ++
 rtl/spi_cs_scheduler.sv | 150 +++++++++++++++
 tb/tb_spi_cs_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_cs_scheduler_if.sv
// Bundles the client request/response side and the SPI_master side of spi_cs_scheduler.
// The scheduler takes the slave modport; whatever drives the requests and models SPI_master takes master.
interface spi_cs_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_data;
  logic                      timeout_err;
  logic [NUM_REQ-1:0]        m_chip_sel;
  logic [DATA_W-1:0]         m_tx_data;
  logic                      m_start;
  logic                      m_done;
  logic [DATA_W-1:0]         m_rx_data;

  modport slave (
    input  req, req_data, m_done, m_rx_data,
    output gnt, done, rsp_data, timeout_err, m_chip_sel, m_tx_data, m_start
  );

  modport master (
    output req, req_data, m_done, m_rx_data,
    input  gnt, done, rsp_data, timeout_err, m_chip_sel, m_tx_data, m_start
  );
endinterface

// File: rtl/spi_cs_scheduler.sv
// Round-robin arbiter and transfer sequencer sharing one SPI_master among NUM_REQ clients.
// Each transfer walks SETUP, START, WAIT, HOLD and GAP, with a saturating abort timer in WAIT.
module spi_cs_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  spi_cs_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               abort_q, abort_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [TMR_W-1:0]   timer_inc;
  logic [NUM_REQ-1:0] sel;
  logic               cs_on;

  // Search requests starting at rr_ptr and wrapping; the first set bit wins.
  // NOTE: every variable an always_comb writes gets a default first, so no path can leave it
  // holding its old value and infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    abort_d   = abort_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    timer_inc = (timer_q == TMR_W'(TIMEOUT)) ? timer_q : timer_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          idx_d    = win_idx;
          tx_d     = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
          rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_START;
      ST_START: begin
        timer_d = '0;
        abort_d = 1'b0;
        rx_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        // A completion on the final permitted cycle beats the abort.
        if (bus.m_done) begin
          rx_d    = bus.m_rx_data;
          state_d = ST_HOLD;
        end else if (timer_inc == TMR_W'(TIMEOUT)) begin
          rx_d    = '0;
          abort_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      abort_q  <= 1'b0;
      timer_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      abort_q  <= abort_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    sel        = '0;
    sel[idx_q] = 1'b1;
  end

  // Outputs decode from the registered state, so they clear in the cycle after a reset edge.
  assign cs_on           = (state_q == ST_SETUP) || (state_q == ST_START) ||
                           (state_q == ST_WAIT)  || (state_q == ST_HOLD);
  assign bus.gnt         = cs_on ? sel : '0;
  assign bus.m_chip_sel  = cs_on ? sel : '0;
  assign bus.m_start     = (state_q == ST_START);
  assign bus.m_tx_data   = tx_q;
  assign bus.done        = (state_q == ST_HOLD) ? sel : '0;
  assign bus.rsp_data    = (state_q == ST_HOLD) ? rx_q : '0;
  assign bus.timeout_err = (state_q == ST_HOLD) && abort_q;

endmodule

// File: tb/tb_spi_cs_scheduler.sv
// Self-checking bench for spi_cs_scheduler: the bench models SPI_master and the clients, and a
// transaction-level model predicts the winner, timing and response of every transfer.
module tb_spi_cs_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_cs_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  spi_cs_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int                 rr_ptr_m;
  logic [NUM_REQ-1:0] req_mask;
  logic [DATA_W-1:0]  tx_word [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_req(input logic [NUM_REQ-1:0] mask);
    req_mask = mask;
    bus.req  = mask;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = tx_word[i];
  endtask

  // Inputs that must not influence a transfer already past IDLE.
  task automatic scramble();
    bus.req      = NUM_REQ'($urandom);
    bus.req_data = (NUM_REQ*DATA_W)'($urandom);
    bus.m_done   = 1'($urandom_range(0, 1));
    bus.m_rx_data = DATA_W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"},   32'(bus.m_chip_sel),  32'd0);
    check({tag, "_gnt"},  32'(bus.gnt),         32'd0);
    check({tag, "_done"}, 32'(bus.done),        32'd0);
    check({tag, "_rsp"},  32'(bus.rsp_data),    32'd0);
    check({tag, "_terr"}, 32'(bus.timeout_err), 32'd0);
    check({tag, "_strt"}, 32'(bus.m_start),     32'd0);
  endtask

  // Entered at the negedge of an IDLE cycle with req_mask driven. n = WAIT cycle in which
  // m_done is raised (0 = never); rst_at = WAIT cycle in which reset is raised (0 = never).
  // Returns at the negedge of the next IDLE cycle.
  task automatic xfer(input int n, input logic [DATA_W-1:0] rx, input int rst_at);
    int                 win;
    int                 w;
    bit                 got_rx;
    logic [NUM_REQ-1:0] oh;
    logic [DATA_W-1:0]  exp_tx;
    win      = pick(req_mask, rr_ptr_m);
    oh       = NUM_REQ'(1) << win;
    exp_tx   = tx_word[win];
    rr_ptr_m = (win + 1) % NUM_REQ;

    @(posedge clk); @(negedge clk);
    check("setup_cs",    32'(bus.m_chip_sel), 32'(oh));
    check("setup_gnt",   32'(bus.gnt),        32'(oh));
    check("setup_tx",    32'(bus.m_tx_data),  32'(exp_tx));
    check("setup_start", 32'(bus.m_start),    32'd0);
    scramble();

    @(posedge clk); @(negedge clk);
    check("start_pulse", 32'(bus.m_start),    32'd1);
    check("start_cs",    32'(bus.m_chip_sel), 32'(oh));
    check("start_tx",    32'(bus.m_tx_data),  32'(exp_tx));
    scramble();

    w = 0;
    while (w < TIMEOUT) begin
      w++;
      @(posedge clk); @(negedge clk);
      check("wait_cs",    32'(bus.m_chip_sel), 32'(oh));
      check("wait_start", 32'(bus.m_start),    32'd0);
      check("wait_done",  32'(bus.done),       32'd0);
      check("wait_tx",    32'(bus.m_tx_data),  32'(exp_tx));
      if (w == rst_at) begin
        reset      = 1'b1;
        bus.m_done = 1'b0;
        @(posedge clk); @(negedge clk);
        check_all_zero("rst");
        reset    = 1'b0;
        rr_ptr_m = 0;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.req      = NUM_REQ'($urandom);
        bus.req_data = (NUM_REQ*DATA_W)'($urandom);
      end
      bus.m_done    = (w == n);
      bus.m_rx_data = (w == n) ? rx : DATA_W'($urandom);
      if (w == n) break;
    end

    @(posedge clk); @(negedge clk);
    got_rx = (n >= 1) && (n <= TIMEOUT);
    check("hold_done", 32'(bus.done),        32'(oh));
    check("hold_rsp",  32'(bus.rsp_data),    got_rx ? 32'(rx) : 32'd0);
    check("hold_terr", 32'(bus.timeout_err), got_rx ? 32'd0 : 32'd1);
    check("hold_cs",   32'(bus.m_chip_sel),  32'(oh));
    check("hold_gnt",  32'(bus.gnt),         32'(oh));
    scramble();

    for (int g = 0; g < GAP_CYC; g++) begin
      @(posedge clk); @(negedge clk);
      check_all_zero("gap");
      scramble();
    end

    // The IDLE cycle that follows the gap also has CS low.
    @(posedge clk); @(negedge clk);
    check("idle_cs",   32'(bus.m_chip_sel), 32'd0);
    check("idle_done", 32'(bus.done),       32'd0);
    bus.m_done = 1'b0;
    set_req(req_mask);
  endtask

  task automatic idle_cycles(input int k);
    set_req('0);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); @(negedge clk);
      check_all_zero("idle");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.m_done    = 1'b0;
    bus.m_rx_data = '0;
    rr_ptr_m      = 0;
    req_mask      = '0;
    for (int i = 0; i < NUM_REQ; i++) tx_word[i] = DATA_W'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_tx", 32'(bus.m_tx_data), 32'd0);
    reset = 1'b0;

    // All requesters held: grants rotate 0,1,2,3,0.
    set_req('1);
    for (int t = 0; t < 5; t++) xfer($urandom_range(1, 12), DATA_W'($urandom), 0);

    // Single requester 0 with a known word.
    tx_word[0] = 8'hA5;
    set_req(4'b0001);
    xfer(10, 8'h3C, 0);

    // Wrap-around: serve 1 so the pointer sits at 2, then 3 beats 1.
    set_req(4'b0010);
    xfer(3, DATA_W'($urandom), 0);
    set_req(4'b1010);
    xfer(4, DATA_W'($urandom), 0);
    set_req(4'b0010);
    xfer(2, DATA_W'($urandom), 0);

    // Abort, then the next requester is served normally.
    set_req(4'b0100);
    xfer(0, DATA_W'($urandom), 0);
    set_req(4'b1000);
    xfer(5, 8'h77, 0);

    // Completion on the last permitted WAIT cycle, and one cycle earlier.
    set_req(4'b0001);
    xfer(TIMEOUT, 8'h5A, 0);
    set_req(4'b0010);
    xfer(TIMEOUT - 1, 8'hC3, 0);

    // Reset during WAIT after the pointer has moved off 0.
    set_req(4'b0001);
    xfer(20, DATA_W'($urandom), 4);
    set_req('1);
    xfer(6, DATA_W'($urandom), 0);

    for (int t = 0; t < 40; t++) begin
      logic [NUM_REQ-1:0] m;
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      for (int i = 0; i < NUM_REQ; i++) tx_word[i] = DATA_W'($urandom);
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      set_req(m);
      xfer(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 30), DATA_W'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
